// File: rtl/clock_set_controller.sv
// Time-setting sequencer: walks hour/min/sec edit fields from MODE/INC button pulses,
// auto-repeats held increments, blinks the selected field and strobes load on exit.
// Optional decrement button enabled by defining CLOCK_SET_DEC_EN.
module clock_set_controller #(
  parameter int REPEAT_BITS    = 21,
  parameter int BLINK_BITS     = 24,
  parameter int TIMEOUT_BLINKS = 16
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       mode_sig,
  input  logic       mode_long,
  input  logic       inc_sig,
  input  logic       inc_long,
  input  logic       inc_held_n,
`ifdef CLOCK_SET_DEC_EN
  input  logic       dec_sig,
  input  logic       dec_long,
  input  logic       dec_held_n,
`endif
  input  logic [4:0] cur_hour,
  input  logic [5:0] cur_min,
  input  logic [5:0] cur_sec,
  output logic [4:0] set_hour,
  output logic [5:0] set_min,
  output logic [5:0] set_sec,
  output logic       editing,
  output logic [1:0] field,
  output logic       blink,
  output logic       load
);

  localparam int IDLE_W = $clog2(TIMEOUT_BLINKS + 1);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HOUR = 2'd1,
    ST_MIN  = 2'd2,
    ST_SEC  = 2'd3
  } state_t;

  state_t                  state, state_d;
  logic [4:0]              set_hour_d;
  logic [5:0]              set_min_d, set_sec_d;
  logic [BLINK_BITS-1:0]   blink_cnt, blink_cnt_d;
  logic [IDLE_W-1:0]       idle_cnt, idle_cnt_d;
  logic [REPEAT_BITS-1:0]  rpt_cnt, rpt_cnt_d;
  logic                    rpt_on, rpt_on_d;
  logic                    rpt_dn, rpt_dn_d;
  logic                    load_d, editing_d, blink_d;

  logic                    dec_sig_w, dec_long_w, dec_held_n_w;
  logic                    inc_evt, dec_evt, step_up, step_dn, held_n_sel, timeout;
  logic [5:0]              hour_step, min_step, sec_step;

`ifdef CLOCK_SET_DEC_EN
  assign dec_sig_w    = dec_sig;
  assign dec_long_w   = dec_long;
  assign dec_held_n_w = dec_held_n;
`else
  assign dec_sig_w    = 1'b0;
  assign dec_long_w   = 1'b0;
  assign dec_held_n_w = 1'b1;
`endif

  function automatic logic [5:0] step_value(input logic [5:0] v, input logic [5:0] max_v,
                                            input logic up);
    if (up) return (v >= max_v) ? 6'd0 : v + 6'd1;
    else    return (v == 6'd0 || v > max_v) ? max_v : v - 6'd1;
  endfunction

  assign field = state;

  // NOTE: every variable driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state;
    set_hour_d  = set_hour;
    set_min_d   = set_min;
    set_sec_d   = set_sec;
    blink_cnt_d = blink_cnt;
    idle_cnt_d  = idle_cnt;
    rpt_cnt_d   = rpt_cnt;
    rpt_on_d    = rpt_on;
    rpt_dn_d    = rpt_dn;
    load_d      = 1'b0;
    step_up     = 1'b0;
    step_dn     = 1'b0;
    timeout     = 1'b0;
    inc_evt     = inc_sig | inc_long;
    dec_evt     = dec_sig_w | dec_long_w;
    held_n_sel  = rpt_dn ? dec_held_n_w : inc_held_n;
    hour_step   = '0;
    min_step    = '0;
    sec_step    = '0;

    if (state == ST_RUN) begin
      if (mode_long) begin
        state_d     = ST_HOUR;
        set_hour_d  = (cur_hour > 5'd23) ? 5'd0 : cur_hour;
        set_min_d   = (cur_min  > 6'd59) ? 6'd0 : cur_min;
        set_sec_d   = (cur_sec  > 6'd59) ? 6'd0 : cur_sec;
        blink_cnt_d = '0;
        idle_cnt_d  = '0;
        rpt_on_d    = 1'b0;
      end
    end else begin
      blink_cnt_d = blink_cnt + 1'b1;
      if (mode_long) begin
        state_d  = ST_RUN;
        load_d   = 1'b1;
        rpt_on_d = 1'b0;
      end else if (mode_sig) begin
        state_d    = (state == ST_SEC) ? ST_HOUR : state_t'(state + 2'd1);
        idle_cnt_d = '0;
        rpt_on_d   = 1'b0;
      end else if (inc_evt && dec_evt) begin
        // Conflicting directions cancel each other and any repeat in progress.
        rpt_on_d = 1'b0;
      end else if (inc_long || dec_long_w) begin
        step_up   = inc_long;
        step_dn   = dec_long_w;
        rpt_on_d  = 1'b1;
        rpt_dn_d  = dec_long_w;
        rpt_cnt_d = '0;
      end else if (inc_sig) begin
        step_up = 1'b1;
        if (rpt_dn) rpt_on_d = 1'b0;
      end else if (dec_sig_w) begin
        step_dn = 1'b1;
        if (!rpt_dn) rpt_on_d = 1'b0;
      end else if (rpt_on) begin
        if (held_n_sel) begin
          rpt_on_d = 1'b0;
        end else begin
          rpt_cnt_d = rpt_cnt + 1'b1;
          if (&rpt_cnt) begin
            step_up = !rpt_dn;
            step_dn = rpt_dn;
          end
        end
      end

      hour_step = step_value({1'b0, set_hour}, 6'd23, step_up);
      min_step  = step_value(set_min, 6'd59, step_up);
      sec_step  = step_value(set_sec, 6'd59, step_up);

      if (step_up || step_dn) begin
        // Restart the blink phase so the freshly adjusted digit is visible.
        blink_cnt_d = '0;
        idle_cnt_d  = '0;
        unique case (state)
          ST_HOUR: set_hour_d = hour_step[4:0];
          ST_MIN:  set_min_d  = min_step;
          ST_SEC:  set_sec_d  = sec_step;
          default: ;
        endcase
      end else if (!mode_long && !mode_sig && (&blink_cnt)) begin
        if (idle_cnt == IDLE_W'(TIMEOUT_BLINKS - 1)) timeout = 1'b1;
        else idle_cnt_d = idle_cnt + 1'b1;
      end

      if (timeout) begin
        state_d    = ST_RUN;
        idle_cnt_d = '0;
        rpt_on_d   = 1'b0;
      end
    end

    editing_d = (state_d != ST_RUN);
    blink_d   = (state_d == ST_RUN) ? 1'b1 : ~blink_cnt_d[BLINK_BITS-1];
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_RUN;
      set_hour  <= '0;
      set_min   <= '0;
      set_sec   <= '0;
      blink_cnt <= '0;
      idle_cnt  <= '0;
      rpt_cnt   <= '0;
      rpt_on    <= 1'b0;
      rpt_dn    <= 1'b0;
      load      <= 1'b0;
      editing   <= 1'b0;
      blink     <= 1'b1;
    end else begin
      state     <= state_d;
      set_hour  <= set_hour_d;
      set_min   <= set_min_d;
      set_sec   <= set_sec_d;
      blink_cnt <= blink_cnt_d;
      idle_cnt  <= idle_cnt_d;
      rpt_cnt   <= rpt_cnt_d;
      rpt_on    <= rpt_on_d;
      rpt_dn    <= rpt_dn_d;
      load      <= load_d;
      editing   <= editing_d;
      blink     <= blink_d;
    end
  end

endmodule

// File: tb/tb_clock_set_controller.sv
// Bench for clock_set_controller: vector table, hand-written corner sequences and a
// randomized run against a cycle-level reference model of the setting rules.
module tb_clock_set_controller;

  localparam int RB = 4;
  localparam int BB = 5;
  localparam int TB = 3;
  localparam int RP = 1 << RB;  // repeat period
  localparam int BP = 1 << BB;  // blink wrap period

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       mode_sig = 0, mode_long = 0, inc_sig = 0, inc_long = 0, inc_held_n = 1;
`ifdef CLOCK_SET_DEC_EN
  logic       dec_sig = 0, dec_long = 0, dec_held_n = 1;
`endif
  logic [4:0] cur_hour = 0;
  logic [5:0] cur_min = 0, cur_sec = 0;
  logic [4:0] set_hour;
  logic [5:0] set_min, set_sec;
  logic       editing, blink, load;
  logic [1:0] field;

  int tests = 0;
  int fails = 0;

  clock_set_controller #(.REPEAT_BITS(RB), .BLINK_BITS(BB), .TIMEOUT_BLINKS(TB)) dut (
    .clock(clock), .reset_n(reset_n),
    .mode_sig(mode_sig), .mode_long(mode_long),
    .inc_sig(inc_sig), .inc_long(inc_long), .inc_held_n(inc_held_n),
`ifdef CLOCK_SET_DEC_EN
    .dec_sig(dec_sig), .dec_long(dec_long), .dec_held_n(dec_held_n),
`endif
    .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
    .set_hour(set_hour), .set_min(set_min), .set_sec(set_sec),
    .editing(editing), .field(field), .blink(blink), .load(load)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One active edge, then settle before sampling.
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    mode_sig = 0; mode_long = 0; inc_sig = 0; inc_long = 0; inc_held_n = 1;
`ifdef CLOCK_SET_DEC_EN
    dec_sig = 0; dec_long = 0; dec_held_n = 1;
`endif
  endtask

  task automatic do_reset();
    clear_inputs();
    reset_n = 0;
    #12;
    reset_n = 1;
    @(negedge clock);
  endtask

  // ---------------- reference model ----------------
  int m_field, m_h, m_m, m_s, m_phase, m_idle, m_rpt_age;
  bit m_rpt, m_load;

  task automatic model_reset();
    m_field = 0; m_h = 0; m_m = 0; m_s = 0; m_phase = 0; m_idle = 0;
    m_rpt_age = 0; m_rpt = 0; m_load = 0;
  endtask

  task automatic model_bump(inout bit stepped);
    stepped = 1;
    case (m_field)
      1: m_h = (m_h + 1) % 24;
      2: m_m = (m_m + 1) % 60;
      3: m_s = (m_s + 1) % 60;
      default: ;
    endcase
  endtask

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_edge();
    bit stepped, wrapped;
    stepped = 0;
    m_load  = 0;
    if (m_field == 0) begin
      if (mode_long) begin
        m_field = 1;
        m_h = (cur_hour > 23) ? 0 : int'(cur_hour);
        m_m = (cur_min  > 59) ? 0 : int'(cur_min);
        m_s = (cur_sec  > 59) ? 0 : int'(cur_sec);
        m_phase = 0; m_idle = 0; m_rpt = 0;
      end
    end else begin
      wrapped = (m_phase == BP - 1);
      m_phase = (m_phase + 1) % BP;
      if (mode_long) begin
        m_field = 0; m_load = 1; m_rpt = 0;
      end else if (mode_sig) begin
        m_field = m_field % 3 + 1; m_idle = 0; m_rpt = 0;
      end else if (inc_long) begin
        model_bump(stepped); m_rpt = 1; m_rpt_age = 0;
      end else if (inc_sig) begin
        model_bump(stepped);
      end else if (m_rpt) begin
        if (inc_held_n) m_rpt = 0;
        else begin
          m_rpt_age++;
          if (m_rpt_age % RP == 0) model_bump(stepped);
        end
      end
      if (stepped) begin
        m_phase = 0; m_idle = 0;
      end else if (m_field != 0 && !mode_sig && wrapped) begin
        m_idle++;
        if (m_idle >= TB) begin
          m_field = 0; m_rpt = 0; m_idle = 0;
        end
      end
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit ms, ml, is;
    int e_field, e_h, e_m, e_s;
    bit e_load;
  } vec_t;

  vec_t vecs[14];

  initial begin
    string nm;
    bit    load_seen;
    int    steps;

    vecs[0]  = '{0,0,0, 0,  0,  0,  0, 0};
    vecs[1]  = '{0,1,0, 1, 23, 59, 58, 0};
    vecs[2]  = '{0,0,1, 1,  0, 59, 58, 0};
    vecs[3]  = '{0,1,0, 0,  0, 59, 58, 1};
    vecs[4]  = '{0,0,0, 0,  0, 59, 58, 0};
    vecs[5]  = '{0,1,0, 1, 23, 59, 58, 0};
    vecs[6]  = '{1,0,1, 2, 23, 59, 58, 0};
    vecs[7]  = '{0,0,1, 2, 23,  0, 58, 0};
    vecs[8]  = '{1,0,0, 3, 23,  0, 58, 0};
    vecs[9]  = '{0,0,1, 3, 23,  0, 59, 0};
    vecs[10] = '{0,0,1, 3, 23,  0,  0, 0};
    vecs[11] = '{1,0,0, 1, 23,  0,  0, 0};
    vecs[12] = '{1,1,1, 0, 23,  0,  0, 1};
    vecs[13] = '{0,0,1, 0, 23,  0,  0, 0};

    // Reset state
    reset_n = 0;
    #12;
    check("rst_field", field, 0);
    check("rst_blink", blink, 1);
    check("rst_load", load, 0);
    reset_n = 1;
    @(negedge clock);

    // Table: one row per clock, live time fixed at 23:59:58
    cur_hour = 23; cur_min = 59; cur_sec = 58;
    foreach (vecs[i]) begin
      mode_sig = vecs[i].ms; mode_long = vecs[i].ml; inc_sig = vecs[i].is;
      cyc();
      nm = $sformatf("vec%0d", i);
      check({nm, "_field"}, field, vecs[i].e_field);
      check({nm, "_editing"}, editing, vecs[i].e_field != 0);
      check({nm, "_hour"}, set_hour, vecs[i].e_h);
      check({nm, "_min"}, set_min, vecs[i].e_m);
      check({nm, "_sec"}, set_sec, vecs[i].e_s);
      check({nm, "_load"}, load, vecs[i].e_load);
      check({nm, "_blink"}, blink, 1);
    end
    clear_inputs();

    // Reset asserted in the middle of a SEC edit
    mode_long = 1; cyc(); mode_long = 0;
    mode_sig = 1; cyc(); cyc(); mode_sig = 0;
    check("pre_rst_field", field, 3);
    @(negedge clock);
    #2 reset_n = 0;
    #1;
    check("midrst_field", field, 0);
    check("midrst_editing", editing, 0);
    check("midrst_hour", set_hour, 0);
    check("midrst_min", set_min, 0);
    check("midrst_sec", set_sec, 0);
    check("midrst_blink", blink, 1);
    #10 reset_n = 1;
    load_seen = 0;
    for (int k = 0; k < 6; k++) begin
      cyc();
      if (load) load_seen = 1;
    end
    check("midrst_no_load", load_seen, 0);

    // Auto-repeat in MIN across the 59->0 wrap
    do_reset();
    cur_hour = 10; cur_min = 57; cur_sec = 0;
    mode_long = 1; cyc(); mode_long = 0;
    mode_sig = 1; cyc(); mode_sig = 0;
    check("rpt_field", field, 2);
    inc_long = 1; inc_held_n = 0; cyc(); inc_long = 0;
    check("rpt_first", set_min, 58);
    for (int k = 1; k <= 40; k++) begin
      cyc();
      if (k == 15) check("rpt_k15", set_min, 58);
      if (k == 16) check("rpt_k16", set_min, 59);
      if (k == 31) check("rpt_k31", set_min, 59);
      if (k == 32) check("rpt_k32", set_min, 0);
      if (k == 40) check("rpt_k40", set_min, 0);
    end
    inc_held_n = 1;
    for (int k = 0; k < 40; k++) cyc();
    check("rpt_released", set_min, 0);
    check("rpt_still_edit", editing, 1);

    // Inactivity timeout: 3 blink-counter wraps of 32 clocks each
    do_reset();
    cur_hour = 5; cur_min = 6; cur_sec = 7;
    mode_long = 1; cyc(); mode_long = 0;
    load_seen = 0;
    steps = 0;
    for (int k = 1; k <= TB * BP; k++) begin
      cyc();
      steps = k;
      if (load) load_seen = 1;
      if (k == TB * BP - 1) check("tmo_before", editing, 1);
    end
    check("tmo_steps", steps, TB * BP);
    check("tmo_editing", editing, 0);
    check("tmo_field", field, 0);
    check("tmo_no_load", load_seen, 0);
    check("tmo_hour_kept", set_hour, 5);
    cyc();
    check("tmo_load_after", load, 0);

`ifdef CLOCK_SET_DEC_EN
    // Decrement wrap and INC+DEC collision
    do_reset();
    cur_hour = 0; cur_min = 0; cur_sec = 0;
    mode_long = 1; cyc(); mode_long = 0;
    dec_sig = 1; cyc(); dec_sig = 0;
    check("dec_wrap", set_hour, 23);
    inc_sig = 1; dec_sig = 1; cyc(); inc_sig = 0; dec_sig = 0;
    check("dec_collide", set_hour, 23);
    clear_inputs();
`endif

    // Randomized run against the model; dense and quiet phases alternate
    do_reset();
    model_reset();
    for (int c = 0; c < 4000; c++) begin
      bit quiet;
      quiet = ((c / 500) % 2) == 1;
      mode_long = ($urandom_range(quiet ? 399 : 59) == 0);
      mode_sig  = !quiet && ($urandom_range(19) == 0);
      inc_sig   = !quiet && ($urandom_range(11) == 0);
      inc_long  = !quiet && ($urandom_range(24) == 0);
      if ($urandom_range(7) == 0) inc_held_n = ~inc_held_n;
      cur_hour  = 5'($urandom_range(31));
      cur_min   = 6'($urandom_range(63));
      cur_sec   = 6'($urandom_range(63));
      model_edge();
      cyc();
      check($sformatf("rnd%0d_field", c), field, m_field);
      check($sformatf("rnd%0d_editing", c), editing, m_field != 0);
      check($sformatf("rnd%0d_hour", c), set_hour, m_h);
      check($sformatf("rnd%0d_min", c), set_min, m_m);
      check($sformatf("rnd%0d_sec", c), set_sec, m_s);
      check($sformatf("rnd%0d_load", c), load, m_load);
      check($sformatf("rnd%0d_blink", c), blink, (m_field == 0) ? 1 : (m_phase < BP / 2));
    end
    clear_inputs();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
